// File: rtl/map_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : map_store_pkg
//  Purpose : Tile codes, palette and FSM state type shared by the map store,
//            the renderer and the game logic.
//  Rev     : 1.0  initial release
// ============================================================================
package map_store_pkg;

   // Tile codes held in each grid cell
   localparam logic [1:0] TILE_EMPTY = 2'd0;
   localparam logic [1:0] TILE_WALL  = 2'd1;
   localparam logic [1:0] TILE_SNAKE = 2'd2;
   localparam logic [1:0] TILE_FOOD  = 2'd3;

   // 2-bit-per-channel colour, packed as {r, g, b}
   typedef struct packed {
      logic [1:0] r;
      logic [1:0] g;
      logic [1:0] b;
   } rgb_t;

   localparam rgb_t PAL_BLACK = '{r: 2'd0, g: 2'd0, b: 2'd0};
   localparam rgb_t PAL_WHITE = '{r: 2'd3, g: 2'd3, b: 2'd3};
   localparam rgb_t PAL_GREEN = '{r: 2'd0, g: 2'd3, b: 2'd0};
   localparam rgb_t PAL_RED   = '{r: 2'd3, g: 2'd0, b: 2'd0};

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } map_state_e;

   // Maps a tile code onto its on-screen colour
   function automatic rgb_t tile_rgb(input logic [1:0] tile);
      rgb_t c;
      case (tile)
         TILE_EMPTY: c = PAL_BLACK;
         TILE_WALL:  c = PAL_WHITE;
         TILE_SNAKE: c = PAL_GREEN;
         default:    c = PAL_RED;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/map_ram.sv
`default_nettype none
// ============================================================================
//  Module  : map_ram
//  Purpose : Simple dual-port RAM, one write port and one registered read
//            port. Reading and writing the same address in one cycle returns
//            the old contents.
//  Rev     : 1.0  initial release
// ============================================================================
module map_ram #(
   parameter int DEPTH  = 1200,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port and registered read port share one block so reads see old data
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/map_store.sv
`default_nettype none
// ============================================================================
//  Module  : map_store
//  Purpose : Block-grid store answering renderer colour reads with one cycle
//            of latency; accepts game-logic tile writes and runs a full-grid
//            clear FSM.
//  Rev     : 1.0  initial release
// ============================================================================
module map_store
   import map_store_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int BLOCK_SIZE    = 16,
   parameter int BLOCK_BITS    = 4,
   parameter int AUTO_CLEAR    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] mapa_x,
   input  logic [9:0] mapa_y,
   input  logic       mapa_read,
   output logic [1:0] mapa_R,
   output logic [1:0] mapa_G,
   output logic [1:0] mapa_B,
   input  logic       wr_en,
   input  logic [9:0] wr_x,
   input  logic [9:0] wr_y,
   input  logic [1:0] wr_tile,
   input  logic       clear_start,
   input  logic [1:0] clear_tile,
   output logic       busy,
   output logic       clear_done
);

   // BLOCK_SIZE is a power of two, so shifting by BLOCK_BITS equals dividing
   localparam int MAP_W  = SCREEN_WIDTH >> BLOCK_BITS;
   localparam int MAP_H  = SCREEN_HEIGHT / BLOCK_SIZE;
   localparam int CELLS  = MAP_W * MAP_H;
   localparam int ADDR_W = $clog2(CELLS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

   map_state_e        state, state_n;
   logic [ADDR_W-1:0] clr_addr, clr_addr_n;
   logic [1:0]        fill, fill_n;
   logic              done_n;

   logic              rd_in_range, wr_in_range;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic              ram_we_c;
   logic [ADDR_W-1:0] ram_waddr;
   logic [1:0]        ram_wdata, ram_rdata;
   logic              rd_valid;
   rgb_t              colour;

   // Out-of-range coordinates are gated before the multiply so they never alias
   assign rd_in_range = (32'(mapa_x) < MAP_W) && (32'(mapa_y) < MAP_H);
   assign wr_in_range = (32'(wr_x) < MAP_W) && (32'(wr_y) < MAP_H);
   assign rd_addr = rd_in_range ? ADDR_W'(32'(mapa_y) * MAP_W + 32'(mapa_x)) : '0;
   assign wr_addr = ADDR_W'(32'(wr_y) * MAP_W + 32'(wr_x));

   // FSM state, clear address, fill code and done pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= (AUTO_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
         clr_addr   <= '0;
         fill       <= TILE_EMPTY;
         clear_done <= 1'b0;
      end else begin
         state      <= state_n;
         clr_addr   <= clr_addr_n;
         fill       <= fill_n;
         clear_done <= done_n;
      end
   end

   // Next-state logic and RAM write-port steering (clear beats game writes)
   always_comb begin
      state_n    = state;
      clr_addr_n = clr_addr;
      fill_n     = fill;
      done_n     = 1'b0;
      ram_we_c   = 1'b0;
      ram_waddr  = wr_addr;
      ram_wdata  = wr_tile;
      case (state)
         ST_IDLE: begin
            if (clear_start) begin
               state_n    = ST_CLEAR;
               clr_addr_n = '0;
               fill_n     = clear_tile;
            end else if (wr_en && wr_in_range) begin
               ram_we_c = 1'b1;
            end
         end
         default: begin
            ram_we_c  = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = fill;
            if (clr_addr == LAST_ADDR) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end else begin
               clr_addr_n = clr_addr + 1'b1;
            end
         end
      endcase
   end

   assign busy = (state == ST_CLEAR);

   map_ram #(
      .DEPTH  (CELLS),
      .ADDR_W (ADDR_W),
      .DATA_W (2)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we_c & ~reset),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (rd_addr),
      .rdata (ram_rdata)
   );

   // Remembers whether last cycle's request was a real in-range read
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= mapa_read & rd_in_range;
      end
   end

   // Blanking and out-of-range requests come out black
   assign colour = rd_valid ? tile_rgb(ram_rdata) : PAL_BLACK;
   assign mapa_R = colour.r;
   assign mapa_G = colour.g;
   assign mapa_B = colour.b;

endmodule
`default_nettype wire
